hazard_stall_ctrl: RTL and testbench

//   Pipeline hazard/stall controller for the 5-stage RISC-V core. Produces the NoOP request

---
 rtl/hazard_stall_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, branch flush, cache-miss freeze.
// Optional perf counters are built only when HAZ_PERF_EN is defined; otherwise they read as zero.
module hazard_stall_ctrl #(
    parameter int MAX_STALL = 256,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       IFID_op_i,
    input  logic [4:0]       IFID_rs1_i,
    input  logic [4:0]       IFID_rs2_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_rd_i,
    input  logic             Branch_taken_i,
    input  logic             dcache_stall_i,
    output logic             NoOP_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             PipeWrite_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] mstall_cnt_o,
    output logic             state_dbg_o
);

    localparam int               SLW     = $clog2(MAX_STALL + 1);
    localparam logic [SLW-1:0]   MAX_LEN = SLW'(MAX_STALL);
    localparam logic [SLW-1:0]   ONE_LEN = SLW'(1);
    localparam logic [6:0]       OP_R    = 7'b0110011;
    localparam logic [6:0]       OP_S    = 7'b0100011;
    localparam logic [6:0]       OP_B    = 7'b1100011;

    typedef enum logic {
        RUN    = 1'b0,
        MSTALL = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ACT_RESET  = 3'd0,
        ACT_FREEZE = 3'd1,
        ACT_LU     = 3'd2,
        ACT_FLUSH  = 3'd3,
        ACT_NORM   = 3'd4
    } action_t;

    state_t         state_q;
    state_t         state_d;
    action_t        action;
    logic           rs1_hit;
    logic           rs2_used;
    logic           rs2_hit;
    logic           lu_hazard;
    logic [SLW-1:0] stall_len_q;
    logic [SLW-1:0] stall_len_d;
    logic           timeout_q;

    // A flushed slot (opcode 0) reads no registers, so it can never hazard.
    always_comb begin
        rs2_used  = (IFID_op_i == OP_R) || (IFID_op_i == OP_S) || (IFID_op_i == OP_B);
        rs1_hit   = (IDEX_rd_i == IFID_rs1_i) && (IFID_op_i != 7'b0);
        rs2_hit   = (IDEX_rd_i == IFID_rs2_i) && rs2_used;
        lu_hazard = IDEX_MemRead_i && (IDEX_rd_i != 5'd0) && (rs1_hit || rs2_hit);
    end

    always_comb begin
        action = ACT_NORM;
        if (rst_i) begin
            action = ACT_RESET;
        end else if (dcache_stall_i) begin
            action = ACT_FREEZE;
        end else if (lu_hazard) begin
            action = ACT_LU;
        end else if (Branch_taken_i) begin
            action = ACT_FLUSH;
        end
    end

    always_comb begin
        NoOP_o       = 1'b0;
        PCWrite_o    = 1'b1;
        IFID_Write_o = 1'b1;
        IFID_Flush_o = 1'b0;
        PipeWrite_o  = 1'b1;
        case (action)
            ACT_RESET: begin
                NoOP_o       = 1'b1;
                PCWrite_o    = 1'b0;
                IFID_Write_o = 1'b0;
                PipeWrite_o  = 1'b0;
            end
            ACT_FREEZE: begin
                PCWrite_o    = 1'b0;
                IFID_Write_o = 1'b0;
                PipeWrite_o  = 1'b0;
            end
            // Taken branch in ID is held; it re-resolves after the bubble.
            ACT_LU: begin
                NoOP_o       = 1'b1;
                PCWrite_o    = 1'b0;
                IFID_Write_o = 1'b0;
            end
            ACT_FLUSH: begin
                IFID_Flush_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Freeze is driven straight from dcache_stall_i, so the FSM only tracks the miss.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (dcache_stall_i)  state_d = MSTALL;
            MSTALL:  if (!dcache_stall_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign state_dbg_o = state_q;

    always_comb begin
        stall_len_d = '0;
        if (dcache_stall_i) begin
            stall_len_d = (stall_len_q == MAX_LEN) ? MAX_LEN : stall_len_q + ONE_LEN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_len_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_len_q <= stall_len_d;
            if (stall_len_d == MAX_LEN) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;

`ifdef HAZ_PERF_EN
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] mstall_cnt_q;

    // Counters saturate rather than wrap; only the winning action of a cycle is counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lu_cnt_q     <= '0;
            flush_cnt_q  <= '0;
            mstall_cnt_q <= '0;
        end else begin
            if ((action == ACT_LU) && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + ONE_CNT;
            end
            if ((action == ACT_FLUSH) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + ONE_CNT;
            end
            if ((action == ACT_FREEZE) && (mstall_cnt_q != '1)) begin
                mstall_cnt_q <= mstall_cnt_q + ONE_CNT;
            end
        end
    end

    assign lu_cnt_o     = lu_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign mstall_cnt_o = mstall_cnt_q;
`else
    assign lu_cnt_o     = '0;
    assign flush_cnt_o  = '0;
    assign mstall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a small watchdog depth and narrow counters.
module tb_hazard_stall_ctrl;

    localparam int MAX_STALL = 4;
    localparam int CNT_W     = 4;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // {NoOP, PCWrite, IFID_Write, IFID_Flush, PipeWrite}
    localparam logic [4:0] C_NORM   = 5'b01101;
    localparam logic [4:0] C_LU     = 5'b10001;
    localparam logic [4:0] C_FLUSH  = 5'b01111;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_RESET  = 5'b10000;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             mem_read;
    logic [4:0]       rd;
    logic             br;
    logic             stall;
    logic             noop;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             pipe_write;
    logic             timeout;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] mstall_cnt;
    logic             state_dbg;

    int               checks   = 0;
    int               failures = 0;
    logic [6:0]       exp_q[$];
    int               exp_lu   = 0;
    int               exp_fl   = 0;
    int               exp_ms   = 0;
    logic             prev_st  = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MAX_STALL(MAX_STALL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .IFID_op_i     (op),
        .IFID_rs1_i    (rs1),
        .IFID_rs2_i    (rs2),
        .IDEX_MemRead_i(mem_read),
        .IDEX_rd_i     (rd),
        .Branch_taken_i(br),
        .dcache_stall_i(stall),
        .NoOP_o        (noop),
        .PCWrite_o     (pc_write),
        .IFID_Write_o  (ifid_write),
        .IFID_Flush_o  (ifid_flush),
        .PipeWrite_o   (pipe_write),
        .timeout_o     (timeout),
        .lu_cnt_o      (lu_cnt),
        .flush_cnt_o   (flush_cnt),
        .mstall_cnt_o  (mstall_cnt),
        .state_dbg_o   (state_dbg)
    );

    function automatic int sat(input int v);
        int r;
        r = (v > 15) ? 15 : v;
`ifndef HAZ_PERF_EN
        r = 0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] observed();
        return {state_dbg, timeout, noop, pc_write, ifid_write, ifid_flush, pipe_write};
    endfunction

    // One pipeline cycle: drive at negedge, compare comb outputs before the next posedge.
    task automatic step(input string tag, input logic [6:0] s_op, input logic [4:0] s_rs1,
                        input logic [4:0] s_rs2, input logic s_mr, input logic [4:0] s_rd,
                        input logic s_br, input logic s_st, input logic [4:0] ec, input logic eto);
        logic [6:0] exp;
        @(negedge clk);
        op       = s_op;
        rs1      = s_rs1;
        rs2      = s_rs2;
        mem_read = s_mr;
        rd       = s_rd;
        br       = s_br;
        stall    = s_st;
        exp_q.push_back({prev_st, eto, ec});
        #2;
        exp = exp_q.pop_front();
        check(tag, 32'(observed()), 32'(exp));
        if (ec == C_LU)     exp_lu++;
        if (ec == C_FLUSH)  exp_fl++;
        if (ec == C_FREEZE) exp_ms++;
        prev_st = s_st;
    endtask

    task automatic check_cnt(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_lu"},  32'(lu_cnt),     32'(sat(exp_lu)));
        check({tag, "_fl"},  32'(flush_cnt),  32'(sat(exp_fl)));
        check({tag, "_ms"},  32'(mstall_cnt), 32'(sat(exp_ms)));
    endtask

    initial begin
        logic [4:0] r;
        rst = 1'b1; op = '0; rs1 = '0; rs2 = '0; mem_read = 1'b0; rd = '0; br = 1'b0; stall = 1'b0;
        #1;
        check("reset_ctrl", 32'(observed()), 32'({1'b0, 1'b0, C_RESET}));
        check("reset_lu", 32'(lu_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // load-use on rs1
        step("lu_rs1",    OP_ADD,  5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, C_LU,   1'b0);
        step("lu_after",  OP_ADD,  5'd5, 5'd6, 1'b0, 5'd5, 1'b0, 1'b0, C_NORM, 1'b0);
        check_cnt("t1");

        // hazard qualifiers
        step("rd_zero",   OP_ADD,  5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, C_NORM, 1'b0);
        step("op_zero",   7'b0,    5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, C_NORM, 1'b0);
        step("addi_rs2",  OP_ADDI, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, C_NORM, 1'b0);
        step("sw_rs2",    OP_SW,   5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, C_LU,   1'b0);
        step("beq_rs2",   OP_BEQ,  5'd2, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, C_LU,   1'b0);
        step("add_rs2",   OP_ADD,  5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, C_LU,   1'b0);

        // flush, and flush masked by load-use
        step("flush",     OP_BEQ,  5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, C_FLUSH, 1'b0);
        step("flush_lu",  OP_BEQ,  5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, C_LU,    1'b0);
        step("flush_re",  OP_BEQ,  5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 1'b0, C_FLUSH, 1'b0);
        check_cnt("t3");

        // watchdog: 3 stall cycles, a gap, then 4 stall cycles trips it
        for (int i = 0; i < 3; i++)
            step("wd_a", OP_ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, C_FREEZE, 1'b0);
        step("wd_gap",   OP_ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM, 1'b0);
        for (int i = 0; i < 4; i++)
            step("wd_b", OP_ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, C_FREEZE, 1'b0);
        step("wd_trip",  OP_ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM, 1'b1);
        step("wd_hold",  OP_ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM, 1'b1);
        check_cnt("t5");

        // miss freeze over a pending load-use, bubble on release
        for (int i = 0; i < 5; i++)
            step("frz_lu", OP_ADD, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1, C_FREEZE, 1'b1);
        step("frz_rel",  OP_ADD, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, C_LU,   1'b1);
        step("frz_done", OP_ADD, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, C_NORM, 1'b1);
        check_cnt("t4");

        // random hazards interleaved with near misses; lu counter saturates
        for (int i = 0; i < 12; i++) begin
            r = 5'($urandom_range(1, 31));
            step("rnd_lu",   OP_ADD, r, 5'($urandom_range(0, 31)), 1'b1, r, 1'b0, 1'b0, C_LU, 1'b1);
            step("rnd_miss", OP_ADD, r ^ 5'd1, r ^ 5'd1, 1'b1, r, 1'b0, 1'b0, C_NORM, 1'b1);
        end
        check_cnt("sat");

        // async reset in the middle of a miss
        step("pre_rst",  OP_ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, C_FREEZE, 1'b1);
        step("in_mst",   OP_ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, C_FREEZE, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        exp_q.push_back({1'b0, 1'b0, C_RESET});
        check("mid_rst_ctrl", 32'(observed()), 32'(exp_q.pop_front()));
        check("mid_rst_lu",   32'(lu_cnt),     32'd0);
        check("mid_rst_fl",   32'(flush_cnt),  32'd0);
        check("mid_rst_ms",   32'(mstall_cnt), 32'd0);
        exp_lu = 0; exp_fl = 0; exp_ms = 0; prev_st = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        step("post_rst", OP_ADD, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM, 1'b0);
        check_cnt("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
